// File: rtl/fetch_pair_queue.sv
// Instruction fetch stage: sequential fetch over a hold-until-ack port into a
// circular FIFO, presenting the two oldest words to the dual-lane scheduler.
module fetch_pair_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     freeze1,
  input  logic                     freeze2,
  output logic [31:0]              instruction0,
  output logic [31:0]              instruction1,
  output logic                     nothing_filled,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     target_q, target_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     mem_q [DEPTH];

  logic            push;
  logic            pop_en;
  logic [CW-1:0]   pop_n;

  always_comb begin
    push     = (state_q == S_WAIT) && mem_ack && !redirect;
    pop_en   = !freeze1 && !freeze2 && (count_q != '0) && !redirect;
    pop_n    = '0;
    if (pop_en) begin
      pop_n = (count_q >= CW'(2)) ? CW'(2) : CW'(1);
    end

    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop_n);
      tail_d  = tail_q + PW'(push);
      count_d = count_q + CW'(push) - pop_n;
    end

    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_WAIT;
        end else if (count_q < CW'(DEPTH)) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          if (mem_ack) begin
            pc_d = redirect_pc;
          end else begin
            target_d = redirect_pc;
            state_d  = S_DRAIN;
          end
        end else if (mem_ack) begin
          pc_d = pc_q + 32'd4;
          if (count_d == CW'(DEPTH)) begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        // pc_q still holds the in-flight address until the stale ack returns
        if (mem_ack) begin
          pc_d    = redirect ? redirect_pc : target_q;
          state_d = S_WAIT;
        end else if (redirect) begin
          target_d = redirect_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= mem_rdata;
    end
  end

  always_comb begin
    mem_req        = (state_q == S_WAIT) || (state_q == S_DRAIN);
    mem_addr       = pc_q;
    nothing_filled = (count_q == '0);
    count          = count_q;
    instruction0   = (count_q != '0)     ? mem_q[head_q]          : '0;
    instruction1   = (count_q >= CW'(2)) ? mem_q[head_q + PW'(1)] : '0;
  end

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Randomized bench for fetch_pair_queue against a queue-based reference model.
module tb_fetch_pair_queue;

  localparam int DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   mem_req;
  logic [31:0]            mem_addr;
  logic                   mem_ack;
  logic [31:0]            mem_rdata;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic                   freeze1;
  logic                   freeze2;
  logic [31:0]            instruction0;
  logic [31:0]            instruction1;
  logic                   nothing_filled;
  logic [$clog2(DEPTH):0] count;

  fetch_pair_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .freeze1        (freeze1),
    .freeze2        (freeze2),
    .instruction0   (instruction0),
    .instruction1   (instruction1),
    .nothing_filled (nothing_filled),
    .count          (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: program-order queue of fetched words plus fetch address.
  logic [31:0] q[$];
  logic [31:0] fetch_pc;
  logic [31:0] drain_addr;
  bit          drain;
  int          starve;

  // Stimulus knobs: ack_mode 0=never 1=always 2=random delay;
  // freeze_mode 0=both low 1=both high 2=random.
  int          ack_mode;
  int          freeze_mode;
  int          redir_pct;
  bit          force_redir;
  logic [31:0] force_pc;
  int          ack_delay;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a == 32'h0000_0200) ? 32'h0 : a + 32'd1;
  endfunction

  task automatic step();
    logic        req_s;
    int          sz;
    int          npop;
    logic [31:0] e0;
    logic [31:0] e1;

    @(negedge clk);
    sz = q.size();
    e0 = (sz >= 1) ? q[0] : 32'h0;
    e1 = (sz >= 2) ? q[1] : 32'h0;
    check_val("count", 32'(count), 32'(sz));
    check_val("nothing_filled", 32'(nothing_filled), 32'(sz == 0));
    check_val("instruction0", instruction0, e0);
    check_val("instruction1", instruction1, e1);
    if (mem_req) check_val("mem_addr", mem_addr, drain ? drain_addr : fetch_pc);
    if (sz == DEPTH) check_val("req_when_full", 32'(mem_req), 32'h0);
    starve = (mem_req || sz == DEPTH) ? 0 : starve + 1;
    check_val("req_starved", 32'(starve > 3), 32'h0);

    case (ack_mode)
      0: mem_ack = 1'b0;
      1: mem_ack = mem_req;
      default: begin
        mem_ack = 1'b0;
        if (mem_req) begin
          if (ack_delay == 0) begin
            mem_ack   = 1'b1;
            ack_delay = $urandom_range(0, 3);
          end else begin
            ack_delay--;
          end
        end
      end
    endcase
    mem_rdata = mem_ack ? word_of(mem_addr) : $urandom;
    case (freeze_mode)
      0: begin freeze1 = 1'b0; freeze2 = 1'b0; end
      1: begin freeze1 = 1'b1; freeze2 = 1'b1; end
      default: begin
        freeze1 = ($urandom_range(0, 2) == 0);
        freeze2 = ($urandom_range(0, 2) == 0);
      end
    endcase
    redirect    = force_redir || ($urandom_range(0, 99) < redir_pct);
    redirect_pc = force_redir ? force_pc : ($urandom & 32'hFFFF_FFFC);
    force_redir = 1'b0;
    req_s       = mem_req;

    @(posedge clk);
    if (redirect) begin
      q.delete();
      if (drain) begin
        drain = !mem_ack;
      end else if (req_s && !mem_ack) begin
        drain      = 1'b1;
        drain_addr = fetch_pc;
      end
      fetch_pc = redirect_pc;
    end else begin
      npop = (!freeze1 && !freeze2) ? ((sz >= 2) ? 2 : sz) : 0;
      repeat (npop) void'(q.pop_front());
      if (req_s && mem_ack) begin
        if (drain) begin
          drain = 1'b0;
        end else begin
          q.push_back(mem_rdata);
          fetch_pc = fetch_pc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    freeze1     = 1'b1;
    freeze2     = 1'b1;
    fetch_pc    = 32'h0;
    drain_addr  = 32'h0;
    drain       = 1'b0;
    starve      = 0;
    ack_mode    = 1;
    freeze_mode = 1;
    redir_pct   = 0;
    force_redir = 1'b0;
    force_pc    = '0;
    ack_delay   = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_mem_req", 32'(mem_req), 32'h0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_count", 32'(count), 32'h0);
    check_val("rst_nothing_filled", 32'(nothing_filled), 32'h1);
    check_val("rst_instruction0", instruction0, 32'h0);
    check_val("rst_instruction1", instruction1, 32'h0);
    rst = 1'b0;

    // Fill from reset with acks every cycle and freezes held.
    repeat (12) step();
    #2;
    check_val("fill_count", 32'(count), 32'd8);
    check_val("fill_mem_req", 32'(mem_req), 32'h0);
    check_val("fill_instruction0", instruction0, 32'd1);
    check_val("fill_instruction1", instruction1, 32'd5);

    freeze_mode = 0;
    step();
    #2;
    check_val("pop_count", 32'(count), 32'd6);
    check_val("pop_instruction0", instruction0, 32'd9);
    check_val("pop_instruction1", instruction1, 32'd13);
    freeze_mode = 1;
    step();
    #2;
    check_val("resume_mem_req", 32'(mem_req), 32'h1);
    check_val("resume_mem_addr", mem_addr, 32'd32);

    // Single entry, then drain it.
    force_redir = 1'b1;
    force_pc    = 32'h40;
    step();
    step();
    ack_mode = 0;
    #2;
    check_val("single_count", 32'(count), 32'd1);
    check_val("single_instruction0", instruction0, 32'h41);
    check_val("single_instruction1", instruction1, 32'h0);
    freeze_mode = 0;
    step();
    #2;
    check_val("single_pop_count", 32'(count), 32'd0);
    check_val("single_pop_empty", 32'(nothing_filled), 32'h1);

    // Redirect coinciding with an ack and a pop.
    ack_mode    = 1;
    freeze_mode = 1;
    repeat (3) step();
    freeze_mode = 0;
    force_redir = 1'b1;
    force_pc    = 32'h300;
    step();
    #2;
    check_val("same_cycle_count", 32'(count), 32'd0);
    check_val("same_cycle_mem_req", 32'(mem_req), 32'h1);
    check_val("same_cycle_mem_addr", mem_addr, 32'h300);

    // Redirect while a request at 0x10 is held, ack delayed 3 cycles.
    freeze_mode = 1;
    force_redir = 1'b1;
    force_pc    = 32'h10;
    step();
    ack_mode    = 0;
    force_redir = 1'b1;
    force_pc    = 32'h100;
    step();
    for (int i = 0; i < 3; i++) begin
      #2;
      check_val("drain_hold_addr", mem_addr, 32'h10);
      step();
    end
    ack_mode = 1;
    step();
    #2;
    check_val("drain_count", 32'(count), 32'd0);
    check_val("drain_mem_req", 32'(mem_req), 32'h1);
    check_val("drain_mem_addr", mem_addr, 32'h100);

    // Randomized traffic: delayed acks, mixed freezes, occasional redirects.
    ack_mode    = 2;
    freeze_mode = 2;
    redir_pct   = 3;
    repeat (1500) step();
    redir_pct   = 0;
    repeat (300) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
